// File: rtl/decoder.sv
// decoder: registered 3-to-8 style line decoder with 74x138 enable pair
// and selectable output polarity; outputs come straight from flops.
module decoder #(
    parameter int SEL_W      = 3,
    parameter bit ACTIVE_LOW = 1'b1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [SEL_W-1:0]      iData,
    input  logic [1:0]            iEna,
    output logic [2**SEL_W-1:0]   oData,
    output logic                  oValid
);
    localparam int N = 2**SEL_W;
    logic [N-1:0] data_d, data_q, hot;
    logic         valid_d, valid_q;
    always_comb begin
        valid_d = iEna[0] & ~iEna[1];
        hot     = valid_d ? (N'(1) << iData) : '0;
        data_d  = ACTIVE_LOW ? ~hot : hot;
    end
    // reset drives every line to the inactive level
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            data_q  <= {N{ACTIVE_LOW}};
            valid_q <= 1'b0;
        end else begin
            data_q  <= data_d;
            valid_q <= valid_d;
        end
    end
    assign oData  = data_q;
    assign oValid = valid_q;
endmodule

// File: tb/tb_decoder.sv
// tb_decoder: table-driven checks of the registered decoder, both polarities,
// plus hand sequences for reset, sampling and async reset.
module tb_decoder;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [2:0] iData = '0;
    logic [1:0] iEna = '0;
    logic [7:0] o_lo, o_hi;
    logic       v_lo, v_hi;
    int         tests = 0;
    int         fails = 0;

    typedef struct {
        logic [1:0] ena;
        logic [2:0] data;
        logic [7:0] exp_data;
        logic       exp_valid;
    } vec_t;
    vec_t vecs[32];

    decoder #(.SEL_W(3), .ACTIVE_LOW(1'b1)) dut (
        .clk(clk), .rst(rst), .iData(iData), .iEna(iEna), .oData(o_lo), .oValid(v_lo));
    decoder #(.SEL_W(3), .ACTIVE_LOW(1'b0)) dut_hi (
        .clk(clk), .rst(rst), .iData(iData), .iEna(iEna), .oData(o_hi), .oValid(v_hi));

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic check_all(input string name, input logic [7:0] exp_lo, input logic [7:0] exp_hi,
                             input logic exp_v);
        check({name, " lo"}, o_lo, exp_lo);
        check({name, " hi"}, o_hi, exp_hi);
        check({name, " vlo"}, {7'd0, v_lo}, {7'd0, exp_v});
        check({name, " vhi"}, {7'd0, v_hi}, {7'd0, exp_v});
    endtask

    initial begin
        logic [7:0] sweep [8];
        logic [1:0] dis [3];
        sweep = '{8'hFE, 8'hFD, 8'hFB, 8'hF7, 8'hEF, 8'hDF, 8'hBF, 8'h7F};
        dis   = '{2'b00, 2'b10, 2'b11};
        for (int i = 0; i < 8; i++) vecs[i] = '{2'b01, 3'(i), sweep[i], 1'b1};
        for (int j = 0; j < 3; j++)
            for (int i = 0; i < 8; i++) vecs[8 + j*8 + i] = '{dis[j], 3'(i), 8'hFF, 1'b0};

        // reset held with enabled inputs present
        iEna = 2'b01; iData = 3'd2;
        repeat (2) @(posedge clk);
        #1 check_all("reset", 8'hFF, 8'h00, 1'b0);
        @(negedge clk) rst = 1'b0;
        @(posedge clk); #1 check_all("post_reset", 8'hFB, 8'h04, 1'b1);

        // table: one vector per cycle, back to back
        foreach (vecs[i]) begin
            @(negedge clk);
            iEna = vecs[i].ena; iData = vecs[i].data;
            @(posedge clk); #1;
            check_all($sformatf("vec%0d", i), vecs[i].exp_data, ~vecs[i].exp_data, vecs[i].exp_valid);
        end

        // mid-cycle change is not seen until the next edge
        @(negedge clk) iEna = 2'b01; iData = 3'd0;
        @(posedge clk); #1 check_all("lat0", 8'hFE, 8'h01, 1'b1);
        #1 iData = 3'd7;
        #1 check_all("lat_hold", 8'hFE, 8'h01, 1'b1);
        @(posedge clk); #1 check_all("lat7", 8'h7F, 8'h80, 1'b1);

        // async reset between edges
        @(negedge clk) iData = 3'd4;
        @(posedge clk); #1 check_all("pre_async", 8'hEF, 8'h10, 1'b1);
        #2 rst = 1'b1;
        #1 check_all("async_rst", 8'hFF, 8'h00, 1'b0);
        @(posedge clk); #1 check_all("rst_hold", 8'hFF, 8'h00, 1'b0);
        @(negedge clk) rst = 1'b0;

        // polarity spot checks
        iEna = 2'b01; iData = 3'd3;
        @(posedge clk); #1 check("pol_en", o_hi, 8'h08);
        @(negedge clk) iEna = 2'b11;
        @(posedge clk); #1 check("pol_dis", o_hi, 8'h00);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
